// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared definitions for the FIFO byte reader.
//   BYTES_PER_WORD / IDX_WIDTH : values for the default 32-bit word.
//   bytes_per_word() / idx_width() : the same values for any DATA_WIDTH.
//   rd_state_e : byte-stream state (IDLE = shift register empty, RUN = holding a word).
package fifo_rd_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_e;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/fifo_byte_reader_shifter.sv
// word_byte_shifter: holds one word and serialises it into bytes.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   load_i           : load load_data_i as a fresh word (byte 0 next)
//   load_data_i      : word to load
//   ready_i          : downstream accepts the current byte
//   data_o           : current byte (register slice, stable while stalled)
//   valid_o          : a byte is presented
//   last_o           : current byte is the last of the word
//   last_xfer_o      : last byte transfers this cycle
module word_byte_shifter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  ready_i,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic                  last_xfer_o
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = idx_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  rd_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [IW-1:0]         idx_q;
  logic                  last_q;
  logic                  xfer;

  assign valid_o     = (state_q == RUN);
  assign xfer        = valid_o & ready_i;
  assign last_xfer_o = xfer & last_q;
  assign last_o      = last_q;

  // The word is shifted so the outgoing byte always sits in a fixed slice;
  // the byte output is then a plain register tap.
  assign data_o = MSB_FIRST ? sh_q[DATA_WIDTH-1 -: 8] : sh_q[7:0];

  always_comb begin
    state_d = state_q;
    if (load_i)           state_d = RUN;
    else if (last_xfer_o) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_i) begin
        sh_q   <= load_data_i;
        idx_q  <= '0;
        last_q <= 1'b0;
      end else if (xfer) begin
        sh_q   <= MSB_FIRST ? (sh_q << 8) : (sh_q >> 8);
        idx_q  <= last_q ? '0 : idx_q + 1'b1;
        // last flag registered one byte ahead so tx_last_o is a flop output
        last_q <= !last_q && (idx_q == LAST_IDX - 1'b1);
      end
    end
  end

endmodule

// File: rtl/fifo_byte_reader.sv
// fifo_byte_reader: drains the sample FIFO and emits its words as a byte stream.
//   clk_i, rst_n_i    : clock, synchronous active-low reset
//   en_i              : 1 = fetch new words, 0 = drain what is held then stop
//   fifo_rd_en_o      : FIFO pop (combinational)
//   fifo_empty_i      : FIFO empty flag
//   fifo_data_i       : FIFO read data, valid the cycle after a pop
//   tx_data_o/valid/ready/last : byte stream handshake
//   underrun_o        : one-cycle pulse when the stream runs dry while enabled
//   underrun_cnt_o    : saturating underrun count
//   idle_o            : nothing held or pending
module fifo_byte_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  output logic                  fifo_rd_en_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  tx_last_o,
  output logic                  underrun_o,
  output logic [CNT_WIDTH-1:0]  underrun_cnt_o,
  output logic                  idle_o
);

  logic                  rd_pending_q;
  logic                  buf_valid_q;
  logic [DATA_WIDTH-1:0] buf_q;

  logic                  last_xfer;
  logic                  sh_free;
  logic                  refill;
  logic                  cap_sh;
  logic                  cap_buf;
  logic                  sh_load;
  logic [DATA_WIDTH-1:0] sh_load_data;
  logic                  ur_event;

  // Only one word may be in flight or parked, so the buffer can never overflow.
  assign fifo_rd_en_o = rst_n_i & en_i & ~fifo_empty_i & ~rd_pending_q & ~buf_valid_q;

  assign sh_free = ~tx_valid_o | last_xfer;
  assign refill  = last_xfer & buf_valid_q;
  // Buffer wins over a capture; the pop rule keeps them from colliding anyway.
  assign cap_sh  = rd_pending_q & sh_free & ~refill;
  assign cap_buf = rd_pending_q & ~sh_free;

  assign sh_load      = refill | cap_sh;
  assign sh_load_data = refill ? buf_q : fifo_data_i;

  // Stream ran dry while still enabled: last byte left and nothing replaces it.
  assign ur_event = last_xfer & en_i & ~sh_load;

  assign idle_o = ~tx_valid_o & ~buf_valid_q & ~rd_pending_q;

  word_byte_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shifter (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .ready_i     (tx_ready_i),
    .data_o      (tx_data_o),
    .valid_o     (tx_valid_o),
    .last_o      (tx_last_o),
    .last_xfer_o (last_xfer)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_pending_q   <= 1'b0;
      buf_valid_q    <= 1'b0;
      buf_q          <= '0;
      underrun_o     <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      rd_pending_q <= fifo_rd_en_o;
      if (cap_buf) begin
        buf_q       <= fifo_data_i;
        buf_valid_q <= 1'b1;
      end else if (refill) begin
        buf_valid_q <= 1'b0;
      end
      underrun_o <= ur_event;
      if (ur_event && (underrun_cnt_o != {CNT_WIDTH{1'b1}}))
        underrun_cnt_o <= underrun_cnt_o + 1'b1;
    end
  end

endmodule
